// File: rtl/draw_text_box.sv
// Text box overlay: generates character/glyph-line addresses for an external
// font ROM, aligns the video stream with the ROM latency and composites glyph
// pixels (with optional transparency and a blinking inverse cursor) over rgb_in.
module draw_text_box #(
  parameter int          XPOS         = 140,
  parameter int          YPOS         = 400,
  parameter int          COLS         = 30,
  parameter int          ROWS         = 4,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h000,
  parameter int          TRANSPARENT  = 0,
  parameter int          ROM_LAT      = 2,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic [11:0] rgb_in,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic [7:0]  char_pixels,
  output logic [6:0]  char_col,
  output logic [4:0]  char_row,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic [11:0] rgb_out
);

  // Box limits held one bit wider so XPOS+8*COLS cannot wrap in the compare.
  localparam logic [11:0] X_LO       = 12'(XPOS);
  localparam logic [11:0] X_HI       = 12'(XPOS + 8 * COLS);
  localparam logic [11:0] Y_LO       = 12'(YPOS);
  localparam logic [11:0] Y_HI       = 12'(YPOS + 16 * ROWS);
  localparam logic [10:0] XPOS_11    = 11'(XPOS);
  localparam logic [10:0] YPOS_11    = 11'(YPOS);
  localparam logic [5:0]  BLINK_LAST = 6'(BLINK_FRAMES - 1);

  logic        in_box;
  logic [6:0]  col_c;
  logic [4:0]  row_c;
  logic [3:0]  line_c;

  logic [10:0] h_d   [ROM_LAT];
  logic [10:0] v_d   [ROM_LAT];
  logic [11:0] rgb_d [ROM_LAT];
  logic        box_d [ROM_LAT];
  logic [6:0]  col_d [ROM_LAT];
  logic [4:0]  row_d [ROM_LAT];

  logic [5:0]  frame_cnt;
  logic        phase;

  logic [2:0]  bit_idx;
  logic        pix;
  logic        cur_hit;
  logic [11:0] rgb_next;

  // Address generation; the box test gates the subtraction so underflow never addresses a cell.
  always_comb begin
    in_box    = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    col_c     = 7'((hcount_in - XPOS_11) >> 3);
    row_c     = 5'((vcount_in - YPOS_11) >> 4);
    line_c    = 4'(vcount_in - YPOS_11);
    char_col  = in_box ? col_c  : 7'd0;
    char_row  = in_box ? row_c  : 5'd0;
    char_line = in_box ? line_c : 4'd0;
  end

  // Delay line matching the font ROM latency.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        h_d[i]   <= '0;
        v_d[i]   <= '0;
        rgb_d[i] <= '0;
        box_d[i] <= 1'b0;
        col_d[i] <= '0;
        row_d[i] <= '0;
      end
    end else begin
      h_d[0]   <= hcount_in;
      v_d[0]   <= vcount_in;
      rgb_d[0] <= rgb_in;
      box_d[0] <= in_box;
      col_d[0] <= col_c;
      row_d[0] <= row_c;
      for (int i = 1; i < ROM_LAT; i++) begin
        h_d[i]   <= h_d[i-1];
        v_d[i]   <= v_d[i-1];
        rgb_d[i] <= rgb_d[i-1];
        box_d[i] <= box_d[i-1];
        col_d[i] <= col_d[i-1];
        row_d[i] <= row_d[i-1];
      end
    end
  end

  // Frame counter and cursor blink phase, stepped at the top-left pixel of each frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (hcount_in == 11'd0 && vcount_in == 11'd0) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  // Pixel decode and colour select on the ROM-aligned stage.
  always_comb begin
    bit_idx = 3'(h_d[ROM_LAT-1] - XPOS_11);
    pix     = char_pixels[3'd7 - bit_idx];
    cur_hit = cursor_en && phase && box_d[ROM_LAT-1] &&
              (col_d[ROM_LAT-1] == cursor_col) && (row_d[ROM_LAT-1] == cursor_row);
    if (!box_d[ROM_LAT-1])
      rgb_next = rgb_d[ROM_LAT-1];
    else if (cur_hit)
      rgb_next = pix ? BG_RGB : FG_RGB;
    else if (pix)
      rgb_next = FG_RGB;
    else
      rgb_next = (TRANSPARENT != 0) ? rgb_d[ROM_LAT-1] : BG_RGB;
  end

  // Output register: adds the final cycle of latency.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= h_d[ROM_LAT-1];
      vcount_out <= v_d[ROM_LAT-1];
      rgb_out    <= rgb_next;
    end
  end

endmodule
